// File: rtl/control_seq_pkg.sv
// rtl/control_seq_pkg.sv - shared opcodes, IR field ranges, states and class type
// Purpose: definitions imported by the control sequencer and its opcode classifier.
// Ports: none (package).
// Optional feature macro: SINGLE_STEP_EN (adds the S_WAIT state).
package control_seq_pkg;

    // Opcodes. 00000..01000 are all three-operand ALU ops.
    localparam logic [4:0] OP_ADD       = 5'b00000;
    localparam logic [4:0] OP_ALU3_LAST = 5'b01000;
    localparam logic [4:0] OP_NOT       = 5'b01001;
    localparam logic [4:0] OP_NEG       = 5'b01010;
    localparam logic [4:0] OP_MUL       = 5'b01011;
    localparam logic [4:0] OP_DIV       = 5'b01100;
    localparam logic [4:0] OP_NOP       = 5'b11110;
    localparam logic [4:0] OP_HALT      = 5'b11111;

    // IR field bit ranges
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
`ifdef SINGLE_STEP_EN
        S_HLT  = 4'd8,
        S_WAIT = 4'd9
`else
        S_HLT  = 4'd8
`endif
    } state_t;

    // One-hot instruction class
    typedef struct packed {
        logic alu3;
        logic unary;
        logic muldiv;
        logic nop;
        logic halt;
        logic illegal;
    } instr_class_t;

endpackage

// File: rtl/control_seq_if.sv
// rtl/control_seq_if.sv - bus between the control sequencer and the datapath
// Purpose: groups IR/mem_ready from the datapath and every control strobe to it.
// Modports: master = sequencer (drives strobes), slave = datapath side (drives IR, mem_ready).
interface control_seq_if #(
    parameter int OP_W      = 5,
    parameter int REG_SEL_W = 4
);
    logic [31:0]          IR;
    logic                 mem_ready;
    logic                 PCout, Zlowout, Zhighout, MDRout;
    logic                 MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin;
    logic                 IncPC, Read;
    logic                 Rout, Rin;
    logic [REG_SEL_W-1:0] rout_sel, rin_sel;
    logic [OP_W-1:0]      op;
    logic                 Run;
    logic                 ill_op;

    modport master (
        input  IR, mem_ready,
        output PCout, Zlowout, Zhighout, MDRout,
        output MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin,
        output IncPC, Read, Rout, Rin, rout_sel, rin_sel, op, Run, ill_op
    );

    modport slave (
        output IR, mem_ready,
        input  PCout, Zlowout, Zhighout, MDRout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin,
        input  IncPC, Read, Rout, Rin, rout_sel, rin_sel, op, Run, ill_op
    );
endinterface

// File: rtl/control_seq_instr_class.sv
// rtl/control_seq_instr_class.sv - combinational opcode to one-hot instruction class
// Purpose: classify IR opcode for the sequencer's next-state and output decode.
// Ports: opcode (in, 5) ; cls (out, instr_class_t one-hot).
module control_seq_instr_class
    import control_seq_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_t cls
);
    always_comb begin
        cls = '0;
        if (opcode <= OP_ALU3_LAST) begin
            cls.alu3 = 1'b1;
        end else begin
            case (opcode)
                OP_NOT, OP_NEG: cls.unary   = 1'b1;
                OP_MUL, OP_DIV: cls.muldiv  = 1'b1;
                OP_NOP:         cls.nop     = 1'b1;
                OP_HALT:        cls.halt    = 1'b1;
                default:        cls.illegal = 1'b1;
            endcase
        end
    end
endmodule

// File: rtl/control_seq.sv
// rtl/control_seq.sv - fetch/decode/execute control sequencer for data_path
// Purpose: Moore FSM stepping T-states per instruction class and driving datapath strobes.
// Ports: Clock (in), clear (in, sync active-high reset), bus (control_seq_if.master:
//        IR/mem_ready in; bus drivers, register loads, IncPC, Read, Rout/Rin + selects,
//        op, Run, ill_op out), step (in, only when SINGLE_STEP_EN is defined).
// Optional feature macro: SINGLE_STEP_EN - parks in WAIT after each instruction until step.
module control_seq
    import control_seq_pkg::*;
#(
    parameter int OP_W      = 5,
    parameter int REG_SEL_W = 4
) (
    input logic           Clock,
    input logic           clear,
`ifdef SINGLE_STEP_EN
    input logic           step,
`endif
    control_seq_if.master bus
);

    // Where execute finishes and where reset releases to
`ifdef SINGLE_STEP_EN
    localparam state_t DONE_ST = S_WAIT;
`else
    localparam state_t DONE_ST = S_T0;
`endif

    state_t       state_q, state_d;
    instr_class_t cls;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       unused_ir_bits;

    assign opcode = bus.IR[OPC_HI:OPC_LO];
    assign ra     = bus.IR[RA_HI:RA_LO];
    assign rb     = bus.IR[RB_HI:RB_LO];
    assign rc     = bus.IR[RC_HI:RC_LO];
    assign unused_ir_bits = ^bus.IR[RC_LO-1:0];

    control_seq_instr_class u_instr_class (
        .opcode (opcode),
        .cls    (cls)
    );

    always_ff @(posedge Clock) begin
        if (clear) state_q <= S_RST;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        bus.PCout    = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.MDRout   = 1'b0;
        bus.MARin    = 1'b0;
        bus.PCin     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.LOin     = 1'b0;
        bus.HIin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Read     = 1'b0;
        bus.Rout     = 1'b0;
        bus.Rin      = 1'b0;
        bus.rout_sel = '0;
        bus.rin_sel  = '0;
        bus.op       = '0;
        bus.Run      = 1'b1;
        bus.ill_op   = 1'b0;

        case (state_q)
            S_RST: state_d = DONE_ST;

            // Z <= PC + 1 while MAR <= PC
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
                state_d   = S_T1;
            end

            // Held until memory data is valid; re-loading PC from an unchanged Z is benign
            S_T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                if (bus.mem_ready) state_d = S_T2;
            end

            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_d    = S_T3;
            end

            S_T3: begin
                if (cls.alu3) begin
                    bus.Rout     = 1'b1;
                    bus.rout_sel = REG_SEL_W'(rb);
                    bus.Yin      = 1'b1;
                    state_d      = S_T4;
                end else if (cls.unary) begin
                    bus.Rout     = 1'b1;
                    bus.rout_sel = REG_SEL_W'(rb);
                    bus.op       = OP_W'(opcode);
                    bus.Zin      = 1'b1;
                    state_d      = S_T4;
                end else if (cls.muldiv) begin
                    bus.Rout     = 1'b1;
                    bus.rout_sel = REG_SEL_W'(ra);
                    bus.Yin      = 1'b1;
                    state_d      = S_T4;
                end else if (cls.halt) begin
                    state_d      = S_HLT;
                end else if (cls.nop || cls.illegal) begin
                    bus.ill_op   = cls.illegal;
                    state_d      = DONE_ST;
                end else begin
                    state_d      = DONE_ST;
                end
            end

            S_T4: begin
                if (cls.alu3 || cls.muldiv) begin
                    bus.Rout     = 1'b1;
                    bus.rout_sel = cls.alu3 ? REG_SEL_W'(rc) : REG_SEL_W'(rb);
                    bus.op       = OP_W'(opcode);
                    bus.Zin      = 1'b1;
                    state_d      = S_T5;
                end else if (cls.unary) begin
                    bus.Zlowout  = 1'b1;
                    bus.Rin      = 1'b1;
                    bus.rin_sel  = REG_SEL_W'(ra);
                    state_d      = DONE_ST;
                end else begin
                    state_d      = DONE_ST;
                end
            end

            S_T5: begin
                if (cls.alu3) begin
                    bus.Zlowout = 1'b1;
                    bus.Rin     = 1'b1;
                    bus.rin_sel = REG_SEL_W'(ra);
                    state_d     = DONE_ST;
                end else if (cls.muldiv) begin
                    bus.Zlowout = 1'b1;
                    bus.LOin    = 1'b1;
                    state_d     = S_T6;
                end else begin
                    state_d     = DONE_ST;
                end
            end

            S_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                state_d      = DONE_ST;
            end

            // Only clear leaves HLT
            S_HLT: bus.Run = 1'b0;

`ifdef SINGLE_STEP_EN
            S_WAIT: begin
                if (step) state_d = S_T0;
            end
`endif

            default: state_d = S_RST;
        endcase
    end

endmodule

// File: tb/tb_control_seq.sv
// tb/tb_control_seq.sv - self-checking bench for control_seq
module tb_control_seq;

    typedef struct packed {
        logic       pcout, zlowout, zhighout, mdrout;
        logic       marin, pcin, mdrin, irin, yin, zin, loin, hiin;
        logic       incpc, read, rout, rin;
        logic [3:0] rout_sel, rin_sel;
        logic [4:0] op;
        logic       run, ill_op;
    } exp_t;

    typedef exp_t exp_q_t[$];

    logic clk;
    logic clear;

    control_seq_if #(.OP_W(5), .REG_SEL_W(4)) bus ();

    control_seq #(.OP_W(5), .REG_SEL_W(4)) dut (
        .Clock (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    int     cycle    = 0;
    exp_t   exp_q[$];
    string  tag_q[$];
    int     t0_cyc[$];

    function automatic exp_t idle();
        exp_t r;
        r     = '0;
        r.run = 1'b1;
        return r;
    endfunction

    function automatic exp_t halted();
        exp_t r;
        r = '0;
        return r;
    endfunction

    function automatic exp_t sample();
        exp_t a;
        a.pcout    = bus.PCout;    a.zlowout = bus.Zlowout; a.zhighout = bus.Zhighout;
        a.mdrout   = bus.MDRout;   a.marin   = bus.MARin;   a.pcin     = bus.PCin;
        a.mdrin    = bus.MDRin;    a.irin    = bus.IRin;    a.yin      = bus.Yin;
        a.zin      = bus.Zin;      a.loin    = bus.LOin;    a.hiin     = bus.HIin;
        a.incpc    = bus.IncPC;    a.read    = bus.Read;    a.rout     = bus.Rout;
        a.rin      = bus.Rin;      a.rout_sel = bus.rout_sel; a.rin_sel = bus.rin_sel;
        a.op       = bus.op;       a.run     = bus.Run;     a.ill_op   = bus.ill_op;
        return a;
    endfunction

    // Execute-phase micro-ops (T3 onward) derived from the instruction class rules
    function automatic exp_q_t exec_model(input logic [31:0] ir);
        exp_q_t     q;
        exp_t       r;
        logic [4:0] opc;
        logic [3:0] ra, rb, rc;
        int         o;
        opc = ir[31:27];
        ra  = ir[26:23];
        rb  = ir[22:19];
        rc  = ir[18:15];
        o   = int'(opc);
        if (o <= 8) begin
            r = idle(); r.rout = 1; r.rout_sel = rb; r.yin = 1; q.push_back(r);
            r = idle(); r.rout = 1; r.rout_sel = rc; r.op = opc; r.zin = 1; q.push_back(r);
            r = idle(); r.zlowout = 1; r.rin = 1; r.rin_sel = ra; q.push_back(r);
        end else if (o == 9 || o == 10) begin
            r = idle(); r.rout = 1; r.rout_sel = rb; r.op = opc; r.zin = 1; q.push_back(r);
            r = idle(); r.zlowout = 1; r.rin = 1; r.rin_sel = ra; q.push_back(r);
        end else if (o == 11 || o == 12) begin
            r = idle(); r.rout = 1; r.rout_sel = ra; r.yin = 1; q.push_back(r);
            r = idle(); r.rout = 1; r.rout_sel = rb; r.op = opc; r.zin = 1; q.push_back(r);
            r = idle(); r.zlowout = 1; r.loin = 1; q.push_back(r);
            r = idle(); r.zhighout = 1; r.hiin = 1; q.push_back(r);
        end else begin
            r = idle(); r.ill_op = (o != 30 && o != 31); q.push_back(r);
        end
        return q;
    endfunction

    // Compare process: one record per cycle, sampled away from the rising edge
    always @(negedge clk) begin
        exp_t  e, a;
        string t;
        cycle++;
        if (bus.PCout === 1'b1) t0_cyc.push_back(cycle);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = sample();
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s cycle=%0d actual=%h expected=%h", t, cycle, a, e);
            end
        end
    end

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_gap(input string name, input int exp);
        int n;
        n = t0_cyc.size();
        if (n < 2) check_val({name, "_t0_seen"}, n, 2);
        else       check_val(name, t0_cyc[n-1] - t0_cyc[n-2], exp);
    endtask

    task automatic cyc(input exp_t r, input string tag, input logic mr);
        bus.mem_ready = mr;
        exp_q.push_back(r);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ir, input int nwait);
        exp_t r;
        bus.IR = ir;
        r = idle(); r.pcout = 1; r.marin = 1; r.incpc = 1; r.zin = 1;
        cyc(r, "t0", 1'b1);
        for (int k = 0; k <= nwait; k++) begin
            r = idle(); r.zlowout = 1; r.pcin = 1; r.read = 1; r.mdrin = 1;
            cyc(r, "t1", (k == nwait));
        end
        r = idle(); r.mdrout = 1; r.irin = 1;
        cyc(r, "t2", 1'b1);
    endtask

    task automatic run_instr(input logic [31:0] ir, input int nwait, input string tag);
        exp_q_t q;
        fetch(ir, nwait);
        q = exec_model(ir);
        foreach (q[i]) cyc(q[i], tag, 1'b1);
        if (ir[31:27] == 5'b11111) begin
            for (int i = 0; i < 20; i++) cyc(halted(), "halted", 1'b1);
        end
    endtask

    initial begin
        exp_q_t q;
        clk           = 1'b0;
        clear         = 1'b1;
        bus.IR        = '0;
        bus.mem_ready = 1'b0;

        // Hand-computed pins on the model
        q = exec_model(32'h01890000);
        check_val("model_add_len", q.size(), 3);
        check_val("model_add_rb", int'(q[0].rout_sel), 1);
        check_val("model_add_rc", int'(q[1].rout_sel), 2);
        check_val("model_add_ra", int'(q[2].rin_sel), 3);
        q = exec_model(32'h4B380000);
        check_val("model_not_len", q.size(), 2);
        check_val("model_not_rb", int'(q[0].rout_sel), 7);
        check_val("model_not_op", int'(q[0].op), 9);
        check_val("model_not_ra", int'(q[1].rin_sel), 6);
        q = exec_model(32'h5A280000);
        check_val("model_mul_len", q.size(), 4);
        check_val("model_mul_ra", int'(q[0].rout_sel), 4);
        q = exec_model(32'hA8000000);
        check_val("model_ill_flag", int'(q[0].ill_op), 1);

        // Reset: two cycles of clear, then RST, then T0
        @(posedge clk);
        @(posedge clk);
        #1;
        clear = 1'b0;
        cyc(idle(), "rst", 1'b1);

        run_instr(32'h01890000, 0, "add");
        run_instr(32'h01890000, 0, "add2");
        check_gap("add_period", 6);
        run_instr(32'h4B380000, 0, "not");
        run_instr(32'hF0000000, 0, "nop");
        check_gap("not_period", 5);
        run_instr(32'h5A280000, 0, "mul");
        run_instr(32'h60000000, 0, "div");
        check_gap("mul_period", 7);
        run_instr(32'h53B80000, 0, "neg");
        run_instr(32'h47878000, 0, "alu3_last");
        run_instr(32'h01890000, 4, "add_wait");
        run_instr(32'hA8000000, 0, "ill_10101");
        run_instr(32'h68000000, 0, "ill_01101");
        run_instr(32'hE8000000, 0, "ill_11101");
        run_instr(32'h4B380000, 0, "not_after_ill");
        check_gap("ill_period", 4);

        // clear during T4 of ADD: RST next, Rin never seen
        fetch(32'h01890000, 0);
        q = exec_model(32'h01890000);
        cyc(q[0], "add_t3_pre_clear", 1'b1);
        clear = 1'b1;
        cyc(q[1], "add_t4_clear", 1'b1);
        clear = 1'b0;
        cyc(idle(), "rst_after_t4_clear", 1'b1);
        run_instr(32'h01890000, 0, "add_after_clear");

        // HALT, 20 idle cycles, then clear restarts
        run_instr(32'hF8000000, 0, "halt");
        clear = 1'b1;
        cyc(halted(), "halt_clear", 1'b1);
        clear = 1'b0;
        cyc(idle(), "rst_after_halt", 1'b1);
        run_instr(32'h4B380000, 1, "not_after_halt");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_seq.md
Name: control_seq

Overview:
- Hardware control sequencer that produces the datapath control strobes (register out/in selects, Yin, Zin, MDR/MAR, PC, ALU op) currently hand-driven by per-instruction benches.
- Fetches an instruction into IR, decodes it, and steps through the execute T-states for each instruction class.
- Sits beside data_path and replaces bench-driven stimulus.

Parameters:
- OP_W, 5, ALU op width sent to data_path.
- REG_SEL_W, 4, register select width (16 GPRs).

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  synchronous active-high reset.
- IR  in  32  instruction register contents from data_path.
- mem_ready  in  1  memory read data valid.
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus drivers.
- MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin  out  1 each  register loads.
- IncPC, Read  out  1 each  PC increment, memory read.
- Rout, Rin  out  1 each  GPR bus-drive / load strobes.
- rout_sel, rin_sel  out  REG_SEL_W  GPR index for Rout / Rin.
- op  out  OP_W  ALU operation.
- Run  out  1  high while executing; low when halted.
- ill_op  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- IR fields: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
- Classes:
  - ALU3: opcode 00000–01000.
  - NOT: 01001.
  - NEG: 01010.
  - MUL: 01011.
  - DIV: 01100.
  - NOP: 11110.
  - HALT: 11111.
  - All others illegal.
- Outputs are Moore, decoded from the state register and IR only. Any strobe not listed for a state is 0. op is 0 except in the Zin state.
- Reset:
  - clear sampled high at an edge puts the FSM in RST in the next cycle, whatever the current state.
  - In RST all strobes, selects, op and ill_op are 0, and Run=1.
  - The first cycle after clear drops is RST; then T0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Stays in T1 while mem_ready=0, holding all four strobes. PCin asserted more than one cycle is harmless because Z is unchanged.
  - T2: MDRout, IRin.
  - Then T3.
- ALU3:
  - T3: Rout, rout_sel=Rb, Yin.
  - T4: Rout, rout_sel=Rc, op=opcode, Zin.
  - T5: Zlowout, Rin, rin_sel=Ra.
  - Then T0. 6 cycles per instruction when mem_ready=1.
- NOT/NEG:
  - T3: Rout, rout_sel=Rb, op=opcode, Zin.
  - T4: Zlowout, Rin, rin_sel=Ra.
  - Then T0. 5 cycles.
- MUL/DIV:
  - T3: Rout Ra, Yin.
  - T4: Rout Rb, op, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
  - Then T0. 7 cycles.
- NOP: T3 has no strobes, then T0.
- Illegal opcode: behaves as NOP, and ill_op=1 during that T3 only.
- HALT: T3 goes to HLT. In HLT, Run=0 and there are no strobes; the FSM stays there until clear.
- IR is only sampled in T3 or later. IR changing after T2 is a datapath error and is not guarded.

Optional Feature:
- Macro SINGLE_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - Every path that would return to T0 after execute goes to WAIT instead.
  - WAIT has no strobes and Run=1. It advances to T0 on the first cycle step=1; holding step high advances one instruction per pass.
  - After clear, RST goes to WAIT.
- Undefined: no step port, no WAIT state, timing as above.

Decomposition:
- Shared include file ctrl_defs.vh holds:
  - opcode localparams (OP_ADD…OP_DIV, OP_NOT=5'b01001, OP_NOP, OP_HALT);
  - state encodings (RST, T0–T6, HLT, WAIT);
  - IR field bit ranges.
- One sub-module, instr_class: combinational opcode to one-hot class (alu3, unary, muldiv, nop, halt, illegal). Used by the FSM next-state and output logic.

Test Plan:
- Reset: clear=1 two cycles, then 0 → RST has all outputs 0 and Run=1; next cycle asserts exactly PCout, MARin, IncPC, Zin.
- ADD R3,R1,R2, IR=32'h01890000, mem_ready=1 →
  - T3: rout_sel=1, Yin;
  - T4: rout_sel=2, op=0, Zin;
  - T5: Zlowout, Rin, rin_sel=3;
  - T0 again 6 cycles after the previous T0.
- NOT R6,R7, IR=32'h4B380000 →
  - T3: rout_sel=7, op=5'b01001, Zin;
  - T4: Zlowout, Rin, rin_sel=6;
  - 5-cycle instruction.
- mem_ready=0 for 4 cycles in T1 → Read/MDRin/PCin held 5 cycles total; IRin one cycle after mem_ready rises.
- HALT, IR=32'hF8000000 → Run=0 the cycle after T3 and no strobes for 20 cycles; clear pulse restarts at RST then T0.
- clear asserted during T4 of ADD → next cycle all outputs 0; Rin for Ra=3 never asserted.
- Illegal opcode 10101 → ill_op high for exactly one cycle, no GPR strobes, next T0 follows.
